// File: rtl/dbus_pkg.sv
// Shared types and constants for the MEM-stage data-bus access controller.
// Contents: access-type and bus-size encodings, request/response structs,
// address-exception codes, controller state encoding, and the
// strobe_type -> bus size mapping used by the controller.
package dbus_pkg;

    localparam int DBUS_ADDR_W = 32;
    localparam int DBUS_DATA_W = 32;
    localparam int DBUS_STRB_W = DBUS_DATA_W / 8;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } strobe_type_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic                   valid;
        logic [DBUS_ADDR_W-1:0] addr;
        msize_t                 size;
        logic [DBUS_STRB_W-1:0] strobe;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_resp_t;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } dbus_state_t;

    // The unused 2'b11 encoding is treated as a byte access.
    function automatic msize_t size_of(input logic [1:0] st);
        case (st)
            2'b00:   return MSIZE4;
            2'b01:   return MSIZE2;
            default: return MSIZE1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_access_ctrl_if.sv
// Data-bus request/response bundle between the MEM-stage controller and
// the memory side.
// master: drives dreq_* (valid, addr, size, strobe, data), receives
//         dresp_* (addr_ok, data_ok, data).
// slave : the memory side, opposite directions.
interface dbus_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  dreq_valid;
    logic [ADDR_W-1:0]     dreq_addr;
    logic [1:0]            dreq_size;
    logic [DATA_W/8-1:0]   dreq_strobe;
    logic [DATA_W-1:0]     dreq_data;
    logic                  dresp_addr_ok;
    logic                  dresp_data_ok;
    logic [DATA_W-1:0]     dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/dbus_align_check.sv
// Combinational misalignment detector for load/store addresses.
// Only built when DBUS_ADDR_EXC_EN is defined; otherwise this file is empty.
// Ports: strobe_type (00 word, 01 half, 10/11 byte), addr_lo (addr[1:0]),
//        misaligned (1 = half on odd address or word not 4-byte aligned).
`ifdef DBUS_ADDR_EXC_EN
module dbus_align_check
    import dbus_pkg::*;
(
    input  logic [1:0] strobe_type,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);
    always_comb begin
        misaligned = 1'b0;
        if (strobe_type == WORD) begin
            misaligned = (addr_lo != 2'b00);
        end else if (strobe_type == HALF) begin
            misaligned = addr_lo[0];
        end
    end
endmodule
`endif

// File: rtl/dbus_access_ctrl.sv
// MEM-stage data-bus access controller. Captures one load/store from the
// store aligner, issues a single request on the data bus (valid/addr_ok/
// data_ok), stalls MEM until the access completes and holds the raw read
// word until the pipeline advances. A flush during an issued access lets
// the bus transaction finish but discards its result.
// Optional feature macro: DBUS_ADDR_EXC_EN (misaligned address exceptions).
// Ports: clk, resetn (async active-low); MEM side mem_valid, mem_write,
//        strobe_type, addr, wstrobe, wdata, flush, mem_advance; results
//        stall, rdata, rdata_valid, exc_valid, exc_code; bus interface
//        dbus (master modport).
//
// state  | meaning
// S_IDLE | no access; capture on mem_valid && !flush
// S_REQ  | request on the bus, waiting for addr_ok
// S_WAIT | request accepted, waiting for data_ok
// S_DONE | result (or exception) held until mem_advance/flush
module dbus_access_ctrl
    import dbus_pkg::*;
#(
    parameter int ADDR_W = DBUS_ADDR_W,
    parameter int DATA_W = DBUS_DATA_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    input  logic                mem_write,
    input  logic [1:0]          strobe_type,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] wstrobe,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                flush,
    input  logic                mem_advance,
    output logic                stall,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_valid,
    output logic                exc_valid,
    output logic [4:0]          exc_code,
    dbus_access_ctrl_if.master  dbus
);
    localparam int STRB_W = DATA_W / 8;

    dbus_state_t        state_q,       state_d;
    logic               discard_q,     discard_d;
    logic               dreq_valid_q,  dreq_valid_d;
    logic [ADDR_W-1:0]  dreq_addr_q,   dreq_addr_d;
    msize_t             dreq_size_q,   dreq_size_d;
    logic [STRB_W-1:0]  dreq_strobe_q, dreq_strobe_d;
    logic [DATA_W-1:0]  dreq_data_q,   dreq_data_d;
    logic [DATA_W-1:0]  rdata_q,       rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               exc_valid_q,   exc_valid_d;
    logic [4:0]         exc_code_q,    exc_code_d;

    logic misaligned;
    logic resp_done;

`ifdef DBUS_ADDR_EXC_EN
    dbus_align_check u_align_check (
        .strobe_type (strobe_type),
        .addr_lo     (addr[1:0]),
        .misaligned  (misaligned)
    );
`else
    assign misaligned = 1'b0;
`endif

    // Response completes the outstanding access: either both handshakes in
    // the same REQ cycle, or data_ok after acceptance.
    assign resp_done = ((state_q == S_REQ) && dbus.dresp_addr_ok && dbus.dresp_data_ok) ||
                       ((state_q == S_WAIT) && dbus.dresp_data_ok);

    always_comb begin
        state_d       = state_q;
        discard_d     = discard_q;
        dreq_valid_d  = dreq_valid_q;
        dreq_addr_d   = dreq_addr_q;
        dreq_size_d   = dreq_size_q;
        dreq_strobe_d = dreq_strobe_q;
        dreq_data_d   = dreq_data_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        exc_valid_d   = exc_valid_q;
        exc_code_d    = exc_code_q;

        case (state_q)
            S_IDLE: begin
                if (mem_valid && !flush) begin
                    if (misaligned) begin
                        state_d       = S_DONE;
                        rdata_d       = '0;
                        rdata_valid_d = 1'b1;
                        exc_valid_d   = 1'b1;
                        exc_code_d    = mem_write ? EXC_ADES : EXC_ADEL;
                    end else begin
                        state_d       = S_REQ;
                        dreq_valid_d  = 1'b1;
                        dreq_addr_d   = addr;
                        dreq_size_d   = size_of(strobe_type);
                        dreq_strobe_d = mem_write ? wstrobe : '0;
                        dreq_data_d   = wdata;
                    end
                end
            end
            S_REQ: begin
                if (flush) discard_d = 1'b1;
                if (dbus.dresp_addr_ok) begin
                    dreq_valid_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) discard_d = 1'b1;
            end
            S_DONE: begin
                if (mem_advance || flush) begin
                    state_d       = S_IDLE;
                    rdata_valid_d = 1'b0;
                    exc_valid_d   = 1'b0;
                    exc_code_d    = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush arriving with data_ok squashes the result as well.
        if (resp_done) begin
            if (discard_q || flush) begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
            end else begin
                state_d       = S_DONE;
                rdata_d       = dbus.dresp_data;
                rdata_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            discard_q     <= 1'b0;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= MSIZE1;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= 5'd0;
        end else begin
            state_q       <= state_d;
            discard_q     <= discard_d;
            dreq_valid_q  <= dreq_valid_d;
            dreq_addr_q   <= dreq_addr_d;
            dreq_size_q   <= dreq_size_d;
            dreq_strobe_q <= dreq_strobe_d;
            dreq_data_q   <= dreq_data_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            exc_valid_q   <= exc_valid_d;
            exc_code_q    <= exc_code_d;
        end
    end

    // IDLE stall follows mem_valid combinationally so capture and stall
    // happen in the same cycle; gated by resetn so reset forces it low.
    assign stall = resetn && ((state_q == S_REQ) || (state_q == S_WAIT) ||
                              ((state_q == S_IDLE) && mem_valid));

    assign rdata            = rdata_q;
    assign rdata_valid      = rdata_valid_q;
    assign exc_valid        = exc_valid_q;
    assign exc_code         = exc_code_q;
    assign dbus.dreq_valid  = dreq_valid_q;
    assign dbus.dreq_addr   = dreq_addr_q;
    assign dbus.dreq_size   = dreq_size_q;
    assign dbus.dreq_strobe = dreq_strobe_q;
    assign dbus.dreq_data   = dreq_data_q;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Testbench for dbus_access_ctrl: directed scenarios with literal
// expectations, then randomized MEM-side and bus-side stimulus checked
// every cycle against a transaction-level model of the access.
module tb_dbus_access_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        mem_valid, mem_write, flush, mem_advance;
    logic [1:0]  strobe_type;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrobe;
    logic        stall, rdata_valid, exc_valid;
    logic [31:0] rdata;
    logic [4:0]  exc_code;

    dbus_access_ctrl_if bus_if ();

    dbus_access_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid   (mem_valid),
        .mem_write   (mem_write),
        .strobe_type (strobe_type),
        .addr        (addr),
        .wstrobe     (wstrobe),
        .wdata       (wdata),
        .flush       (flush),
        .mem_advance (mem_advance),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .dbus        (bus_if.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_out;      // an access has been issued and not yet answered
    bit          m_shown;    // its request is still offered (not yet accepted)
    bit          m_squash;   // its result will be thrown away
    bit          m_held;     // a result is being presented to the pipeline
    bit          m_exc;
    logic [4:0]  m_code;
    logic [31:0] m_rdata, m_addr, m_data;
    logic [1:0]  m_size;
    logic [3:0]  m_strb;

    function automatic bit misaligned_model(input logic [1:0] st, input logic [31:0] a);
`ifdef DBUS_ADDR_EXC_EN
        int nbytes;
        nbytes = (st == 2'b00) ? 4 : (st == 2'b01) ? 2 : 1;
        return (a % nbytes) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_out = 0; m_shown = 0; m_squash = 0; m_held = 0; m_exc = 0;
        m_code = '0; m_rdata = '0; m_addr = '0; m_data = '0; m_size = '0; m_strb = '0;
    endtask

    task automatic model_step();
        bit squashed, accepted;
        if (m_out) begin
            squashed = m_squash || flush;
            accepted = !m_shown || bus_if.dresp_addr_ok;
            if (m_shown && bus_if.dresp_addr_ok) m_shown = 0;
            m_squash = squashed;
            if (accepted && bus_if.dresp_data_ok) begin
                m_out = 0;
                m_squash = 0;
                if (!squashed) begin
                    m_held = 1;
                    m_rdata = bus_if.dresp_data;
                end
            end
        end else if (m_held) begin
            if (mem_advance || flush) begin
                m_held = 0; m_exc = 0; m_code = '0;
            end
        end else if (mem_valid && !flush) begin
            if (misaligned_model(strobe_type, addr)) begin
                m_held = 1; m_exc = 1; m_rdata = '0;
                m_code = mem_write ? 5'd5 : 5'd4;
            end else begin
                m_out = 1; m_shown = 1;
                m_addr = addr;
                m_size = (strobe_type == 2'b00) ? 2'd2 : (strobe_type == 2'b01) ? 2'd1 : 2'd0;
                m_strb = mem_write ? wstrobe : 4'b0000;
                m_data = wdata;
            end
        end
    endtask

    always @(negedge resetn) model_reset();
    always @(posedge clk) if (resetn) model_step();

    // One compare per cycle, after the negedge input update has settled.
    always @(negedge clk) begin
        #1;
        chk("stall",       64'(stall),              64'(resetn && (m_out || (!m_held && mem_valid))));
        chk("dreq_valid",  64'(bus_if.dreq_valid),  64'(m_shown));
        chk("dreq_addr",   64'(bus_if.dreq_addr),   64'(m_addr));
        chk("dreq_size",   64'(bus_if.dreq_size),   64'(m_size));
        chk("dreq_strobe", 64'(bus_if.dreq_strobe), 64'(m_strb));
        chk("dreq_data",   64'(bus_if.dreq_data),   64'(m_data));
        chk("rdata_valid", 64'(rdata_valid),        64'(m_held));
        chk("rdata",       64'(rdata),              64'(m_rdata));
        chk("exc_valid",   64'(exc_valid),          64'(m_exc));
        chk("exc_code",    64'(exc_code),           64'(m_code));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit mv, input bit wr, input logic [1:0] st, input logic [31:0] a,
                         input logic [3:0] sb, input logic [31:0] wd, input bit fl, input bit adv,
                         input bit aok, input bit dok, input logic [31:0] rd);
        @(negedge clk);
        mem_valid = mv; mem_write = wr; strobe_type = st; addr = a; wstrobe = sb; wdata = wd;
        flush = fl; mem_advance = adv;
        bus_if.dresp_addr_ok = aok; bus_if.dresp_data_ok = dok; bus_if.dresp_data = rd;
        #2;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        model_reset();
        mem_valid = 0; mem_write = 0; strobe_type = 0; addr = 0; wstrobe = 0; wdata = 0;
        flush = 0; mem_advance = 0;
        bus_if.dresp_addr_ok = 0; bus_if.dresp_data_ok = 0; bus_if.dresp_data = 0;

        idle_cycle();
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
        chk("reset_rdata_valid", 64'(rdata_valid), 64'd0);
        @(negedge clk); resetn = 1'b1;

        // Word store, addr_ok on the 2nd request cycle, data_ok one later.
        drive(1, 1, 2'b00, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0);
        chk("ws_capture_stall", 64'(stall), 64'd1);
        chk("ws_capture_noreq", 64'(bus_if.dreq_valid), 64'd0);
        drive(1, 1, 2'b00, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0);
        chk("ws_req1_valid", 64'(bus_if.dreq_valid), 64'd1);
        chk("ws_req1_size", 64'(bus_if.dreq_size), 64'd2);
        chk("ws_req1_addr", 64'(bus_if.dreq_addr), 64'h100);
        chk("ws_req1_data", 64'(bus_if.dreq_data), 64'hDEADBEEF);
        drive(1, 1, 2'b00, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0);
        chk("ws_req2_valid", 64'(bus_if.dreq_valid), 64'd1);
        drive(1, 1, 2'b00, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0);
        chk("ws_wait_novalid", 64'(bus_if.dreq_valid), 64'd0);
        chk("ws_wait_stall", 64'(stall), 64'd1);
        drive(1, 1, 2'b00, 32'h100, 4'hF, 32'hDEADBEEF, 0, 1, 0, 0, 32'h0);
        chk("ws_done_stall", 64'(stall), 64'd0);
        chk("ws_done_valid", 64'(rdata_valid), 64'd1);
        idle_cycle();
        chk("ws_after_valid", 64'(rdata_valid), 64'd0);

        // Byte load, addr_ok and data_ok together.
        drive(1, 0, 2'b10, 32'h203, 4'b1000, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 2'b10, 32'h203, 4'b1000, 32'h0, 0, 0, 1, 1, 32'h11223344);
        chk("bl_size", 64'(bus_if.dreq_size), 64'd0);
        chk("bl_strobe", 64'(bus_if.dreq_strobe), 64'd0);
        drive(1, 0, 2'b10, 32'h203, 4'b1000, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("bl_rdata", 64'(rdata), 64'h11223344);
        chk("bl_valid", 64'(rdata_valid), 64'd1);
        drive(1, 0, 2'b10, 32'h203, 4'b1000, 32'h0, 0, 1, 0, 0, 32'h0);
        chk("bl_hold_valid", 64'(rdata_valid), 64'd1);
        idle_cycle();
        chk("bl_after_valid", 64'(rdata_valid), 64'd0);

        // Flush while waiting for data_ok, then a fresh request.
        drive(1, 0, 2'b00, 32'h300, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 2'b00, 32'h300, 4'h0, 32'h0, 0, 0, 1, 0, 32'h0);
        drive(1, 0, 2'b00, 32'h300, 4'h0, 32'h0, 1, 0, 0, 0, 32'h0);
        chk("fl_wait_stall", 64'(stall), 64'd1);
        drive(0, 0, 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h0000CAFE);
        chk("fl_dok_stall", 64'(stall), 64'd1);
        idle_cycle();
        chk("fl_no_result", 64'(rdata_valid), 64'd0);
        chk("fl_idle_stall", 64'(stall), 64'd0);
        drive(1, 1, 2'b01, 32'h304, 4'b0011, 32'h0000ABCD, 0, 0, 0, 0, 32'h0);
        drive(1, 1, 2'b01, 32'h304, 4'b0011, 32'h0000ABCD, 0, 0, 1, 1, 32'h0);
        chk("fl_next_valid", 64'(bus_if.dreq_valid), 64'd1);
        chk("fl_next_addr", 64'(bus_if.dreq_addr), 64'h304);
        drive(1, 1, 2'b01, 32'h304, 4'b0011, 32'h0000ABCD, 0, 1, 0, 0, 32'h0);
        chk("fl_next_done", 64'(rdata_valid), 64'd1);

        // Reset asserted while waiting for data_ok.
        drive(1, 0, 2'b00, 32'h400, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 2'b00, 32'h400, 4'h0, 32'h0, 0, 0, 1, 0, 32'h0);
        drive(1, 0, 2'b00, 32'h400, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        resetn = 1'b0;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_dreq_addr", 64'(bus_if.dreq_addr), 64'd0);
        @(negedge clk); resetn = 1'b1;
        drive(0, 0, 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h55AA55AA);
        idle_cycle();
        chk("rst_late_dok", 64'(rdata_valid), 64'd0);
        chk("rst_late_rdata", 64'(rdata), 64'd0);

`ifdef DBUS_ADDR_EXC_EN
        drive(1, 1, 2'b01, 32'h101, 4'b0110, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(1, 1, 2'b01, 32'h101, 4'b0110, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("ades_noreq", 64'(bus_if.dreq_valid), 64'd0);
        chk("ades_valid", 64'(exc_valid), 64'd1);
        chk("ades_code", 64'(exc_code), 64'd5);
        chk("ades_stall", 64'(stall), 64'd0);
        drive(1, 1, 2'b01, 32'h101, 4'b0110, 32'h0, 0, 1, 0, 0, 32'h0);
        drive(1, 0, 2'b00, 32'h102, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 2'b00, 32'h102, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("adel_code", 64'(exc_code), 64'd4);
        drive(1, 0, 2'b00, 32'h102, 4'h0, 32'h0, 0, 1, 0, 0, 32'h0);
        idle_cycle();
        chk("adel_clear", 64'(exc_valid), 64'd0);
`endif

        // Randomized phase, bus responses kept protocol-legal from the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!resetn) resetn = 1'b1;
            else if ($urandom_range(399) == 0) resetn = 1'b0;
            mem_valid   = ($urandom_range(99) < 60);
            mem_write   = 1'($urandom_range(1));
            strobe_type = 2'($urandom_range(3));
            addr        = $urandom;
            wstrobe     = 4'($urandom);
            wdata       = $urandom;
            flush       = ($urandom_range(99) < 8);
            mem_advance = ($urandom_range(99) < 40);
            if (m_shown) bus_if.dresp_addr_ok = ($urandom_range(99) < 50);
            else         bus_if.dresp_addr_ok = ($urandom_range(99) < 10);
            if (m_out && (!m_shown || bus_if.dresp_addr_ok))
                bus_if.dresp_data_ok = ($urandom_range(99) < 45);
            else if (!m_out)
                bus_if.dresp_data_ok = ($urandom_range(99) < 10);
            else
                bus_if.dresp_data_ok = 1'b0;
            bus_if.dresp_data = $urandom;
        end

        @(negedge clk); resetn = 1'b1;
        idle_cycle();
        idle_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
